// File: rtl/tl_pkg.sv
// Shared TileLink definitions: A/D channel opcodes and the beats-per-message
// helper used by devices that split a transfer into bus-width beats.
package tl_pkg;

    typedef enum logic [2:0] {
        TL_A_PUT_FULL    = 3'd0,
        TL_A_PUT_PARTIAL = 3'd1,
        TL_A_ARITHMETIC  = 3'd2,
        TL_A_LOGICAL     = 3'd3,
        TL_A_GET         = 3'd4,
        TL_A_INTENT      = 3'd5,
        TL_A_ACQ_BLOCK   = 3'd6,
        TL_A_ACQ_PERM    = 3'd7
    } tl_a_op_e;

    typedef enum logic [2:0] {
        TL_D_ACCESS_ACK      = 3'd0,
        TL_D_ACCESS_ACK_DATA = 3'd1,
        TL_D_HINT_ACK        = 3'd2,
        TL_D_GRANT           = 3'd4,
        TL_D_GRANT_DATA      = 3'd5,
        TL_D_RELEASE_ACK     = 3'd6
    } tl_d_op_e;

    // Messages no larger than one bus word still occupy a single beat.
    function automatic int tl_beats(input int size, input int mask_width);
        int bytes;
        bytes = 1 << size;
        return (bytes <= mask_width) ? 1 : bytes / mask_width;
    endfunction

endpackage

// File: rtl/tl_channel.sv
// TileLink link bundle (A/B/C/D/E). Only valid/ready exist on B, C and E,
// since TL-UH endpoints never exchange messages on those channels.
interface tl_channel
    import tl_pkg::*;
#(
    parameter int SourceWidth = 1,
    parameter int SinkWidth   = 1,
    parameter int AddrWidth   = 56,
    parameter int DataWidth   = 64,
    parameter int SizeWidth   = 3
);
    localparam int MaskWidth = DataWidth / 8;

    logic                   a_valid;
    logic                   a_ready;
    tl_a_op_e               a_opcode;
    logic [2:0]             a_param;
    logic [SizeWidth-1:0]   a_size;
    logic [SourceWidth-1:0] a_source;
    logic [AddrWidth-1:0]   a_address;
    logic [MaskWidth-1:0]   a_mask;
    logic [DataWidth-1:0]   a_data;
    logic                   a_corrupt;

    logic                   b_valid;
    logic                   b_ready;
    logic                   c_valid;
    logic                   c_ready;
    logic                   e_valid;
    logic                   e_ready;

    logic                   d_valid;
    logic                   d_ready;
    tl_d_op_e               d_opcode;
    logic [1:0]             d_param;
    logic [SizeWidth-1:0]   d_size;
    logic [SourceWidth-1:0] d_source;
    logic [SinkWidth-1:0]   d_sink;
    logic                   d_denied;
    logic [DataWidth-1:0]   d_data;
    logic                   d_corrupt;

    modport device (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output b_valid, input b_ready,
        input  c_valid, output c_ready,
        input  e_valid, output e_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        input  d_ready
    );

    modport host (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  b_valid, output b_ready,
        output c_valid, input c_ready,
        output e_valid, input e_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        output d_ready
    );

endinterface

// File: rtl/tl_bram_rsp_fifo.sv
// Two-entry response FIFO for D data beats. Fall-through when empty, so a
// word arriving from the SRAM can be presented on D in the same cycle.
module tl_bram_rsp_fifo #(
    parameter int Width = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [Width-1:0] data,
    output logic [1:0]       count
);

    logic [Width-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;

    logic empty;
    logic bypass;
    logic do_push;
    logic do_pop;

    assign empty   = (count_reg == 2'd0);
    // A word consumed in its arrival cycle never enters storage.
    assign bypass  = empty && push && pop;
    assign do_push = push && !bypass;
    assign do_pop  = pop && !empty;

    assign valid = !empty || push;
    assign data  = empty ? push_data : mem_reg[rd_ptr_reg];
    assign count = count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/tl_bram_device.sv
// TL-UH leaf device serving Get/Put (incl. bursts) from a 1-cycle-latency SRAM.
// Define TL_BRAM_DEVICE_HINT_EN to grant Intent hints instead of denying them.
module tl_bram_device
    import tl_pkg::*;
#(
    parameter int SourceWidth   = 1,
    parameter int SinkWidth     = 1,
    parameter int AddrWidth     = 56,
    parameter int DataWidth     = 64,
    parameter int SizeWidth     = 3,
    parameter int SinkId        = 0,
    parameter int SramAddrWidth = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    tl_channel.device                  host,
    output logic                       sram_req_o,
    output logic                       sram_we_o,
    output logic [SramAddrWidth-1:0]   sram_addr_o,
    output logic [DataWidth/8-1:0]     sram_wmask_o,
    output logic [DataWidth-1:0]       sram_wdata_o,
    input  logic [DataWidth-1:0]       sram_rdata_i
);

    localparam int MaskWidth = DataWidth / 8;
    localparam int OffW      = $clog2(MaskWidth);
    localparam int MaxBeats  = tl_beats((1 << SizeWidth) - 1, MaskWidth);
    localparam int IdxW      = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;
    localparam int CntW      = IdxW + 1;

`ifdef TL_BRAM_DEVICE_HINT_EN
    localparam logic HintDenied = 1'b0;
`else
    localparam logic HintDenied = 1'b1;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DRAIN,
        ST_READ,
        ST_ACK,
        ST_DENY
    } state_e;

    state_e                   state_reg, state_next;
    logic [SourceWidth-1:0]   source_reg;
    logic [SizeWidth-1:0]     size_reg;
    logic [SramAddrWidth-1:0] base_reg;
    logic [CntW-1:0]          beats_reg;
    logic [CntW-1:0]          a_cnt_reg;
    logic [CntW-1:0]          rd_cnt_reg;
    logic [CntW-1:0]          d_cnt_reg;
    logic                     inflight_reg;
    tl_d_op_e                 ack_op_reg;
    logic                     ack_denied_reg;

    logic                     a_ready_int;
    logic                     a_fire;
    logic                     a_is_put;
    logic [SramAddrWidth-1:0] a_word;
    logic [CntW-1:0]          a_beats;
    logic [CntW-1:0]          last_beat;
    logic                     wr_fire;
    logic                     rd_issue;
    logic [1:0]               occupancy;
    logic [IdxW-1:0]          beat_idx;
    logic [SramAddrWidth-1:0] burst_addr;
    logic                     d_valid_int;
    logic                     d_fire;

    logic                     fifo_valid;
    logic [DataWidth-1:0]     fifo_data;
    logic [1:0]               fifo_count;
    logic                     fifo_pop;

    // Fields with no role in a TL-UH slave: A param/corrupt, upper/lower address bits, B/C/E.
    logic unused_inputs;
    assign unused_inputs = ^{host.a_param, host.a_corrupt, host.a_address,
                             host.b_ready, host.c_valid, host.e_valid};

    assign host.b_valid = 1'b0;
    assign host.c_ready = 1'b1;
    assign host.e_ready = 1'b1;

    assign a_ready_int = !rst_i && (state_reg == ST_IDLE || state_reg == ST_WRITE ||
                                    state_reg == ST_DRAIN);
    assign host.a_ready = a_ready_int;
    assign a_fire     = host.a_valid && a_ready_int;
    assign a_is_put   = (host.a_opcode == TL_A_PUT_FULL) || (host.a_opcode == TL_A_PUT_PARTIAL);
    assign a_word     = host.a_address[OffW +: SramAddrWidth];
    assign a_beats    = CntW'(tl_beats(int'(host.a_size), MaskWidth));
    assign last_beat  = beats_reg - CntW'(1);

    assign wr_fire = a_fire && ((state_reg == ST_IDLE && a_is_put) || state_reg == ST_WRITE);

    // At most two words may be owed to the FIFO, counting reads still in the SRAM pipe.
    assign occupancy = fifo_count + {1'b0, inflight_reg};
    assign rd_issue  = (state_reg == ST_READ) && (rd_cnt_reg < beats_reg) && (occupancy < 2'd2);

    assign beat_idx   = (state_reg == ST_WRITE) ? a_cnt_reg[IdxW-1:0] : rd_cnt_reg[IdxW-1:0];
    assign burst_addr = base_reg | SramAddrWidth'(beat_idx);

    assign sram_req_o   = wr_fire || rd_issue;
    assign sram_we_o    = wr_fire;
    assign sram_addr_o  = (state_reg == ST_IDLE) ? a_word : burst_addr;
    assign sram_wmask_o = wr_fire ? host.a_mask : '0;
    assign sram_wdata_o = wr_fire ? host.a_data : '0;

    assign fifo_pop = (state_reg == ST_READ) && host.d_ready && fifo_valid;
    assign d_fire   = d_valid_int && host.d_ready;

    tl_bram_rsp_fifo #(
        .Width (DataWidth)
    ) u_rsp_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (inflight_reg),
        .push_data (sram_rdata_i),
        .pop       (fifo_pop),
        .valid     (fifo_valid),
        .data      (fifo_data),
        .count     (fifo_count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (a_fire) begin
                    case (host.a_opcode)
                        TL_A_GET:         state_next = ST_READ;
                        TL_A_PUT_FULL,
                        TL_A_PUT_PARTIAL: state_next = (a_beats > CntW'(1)) ? ST_WRITE : ST_ACK;
                        TL_A_ARITHMETIC,
                        TL_A_LOGICAL:     state_next = (a_beats > CntW'(1)) ? ST_DRAIN : ST_DENY;
                        TL_A_INTENT:      state_next = ST_ACK;
                        default:          state_next = ST_IDLE;
                    endcase
                end
            end
            ST_WRITE: begin
                if (a_fire && a_cnt_reg == last_beat) begin
                    state_next = ST_ACK;
                end
            end
            ST_DRAIN: begin
                if (a_fire && a_cnt_reg == last_beat) begin
                    state_next = ST_DENY;
                end
            end
            ST_READ: begin
                if (d_fire && d_cnt_reg == last_beat) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (host.d_ready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DENY: begin
                if (host.d_ready && d_cnt_reg == last_beat) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            source_reg     <= '0;
            size_reg       <= '0;
            base_reg       <= '0;
            beats_reg      <= '0;
            a_cnt_reg      <= '0;
            rd_cnt_reg     <= '0;
            d_cnt_reg      <= '0;
            inflight_reg   <= 1'b0;
            ack_op_reg     <= TL_D_ACCESS_ACK;
            ack_denied_reg <= 1'b0;
        end else begin
            inflight_reg <= rd_issue;
            if (state_reg == ST_IDLE && a_fire) begin
                source_reg     <= host.a_source;
                size_reg       <= host.a_size;
                base_reg       <= a_word;
                beats_reg      <= a_beats;
                a_cnt_reg      <= CntW'(1);
                rd_cnt_reg     <= '0;
                d_cnt_reg      <= '0;
                ack_op_reg     <= (host.a_opcode == TL_A_INTENT) ? TL_D_HINT_ACK : TL_D_ACCESS_ACK;
                ack_denied_reg <= (host.a_opcode == TL_A_INTENT) ? HintDenied : 1'b0;
            end else if (a_fire) begin
                a_cnt_reg <= a_cnt_reg + CntW'(1);
            end
            if (rd_issue) begin
                rd_cnt_reg <= rd_cnt_reg + CntW'(1);
            end
            if (d_fire && (state_reg == ST_READ || state_reg == ST_DENY)) begin
                d_cnt_reg <= d_cnt_reg + CntW'(1);
            end
        end
    end

    // D fields are pure functions of registered state, so they hold while d_ready is low.
    always_comb begin
        d_valid_int    = 1'b0;
        host.d_opcode  = TL_D_ACCESS_ACK;
        host.d_param   = 2'd0;
        host.d_size    = size_reg;
        host.d_source  = source_reg;
        host.d_sink    = SinkWidth'(SinkId);
        host.d_denied  = 1'b0;
        host.d_data    = '0;
        host.d_corrupt = 1'b0;
        case (state_reg)
            ST_READ: begin
                d_valid_int   = fifo_valid;
                host.d_opcode = TL_D_ACCESS_ACK_DATA;
                host.d_data   = fifo_data;
            end
            ST_ACK: begin
                d_valid_int   = 1'b1;
                host.d_opcode = ack_op_reg;
                host.d_denied = ack_denied_reg;
            end
            ST_DENY: begin
                d_valid_int    = 1'b1;
                host.d_opcode  = TL_D_ACCESS_ACK_DATA;
                host.d_denied  = 1'b1;
                host.d_corrupt = 1'b1;
            end
            default: ;
        endcase
    end

    assign host.d_valid = d_valid_int;

endmodule

// File: tb/tb_tl_bram_device.sv
// Scoreboard bench for tl_bram_device: expected D beats are queued as A
// traffic is driven and compared as the device emits them.
module tb_tl_bram_device;
    import tl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        sram_req;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [7:0]  sram_wmask;
    logic [63:0] sram_wdata;
    logic [63:0] sram_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int write_count = 0;
    int ready_mode = 0;
    bit stall_pending = 1'b0;

    typedef struct packed {
        logic [2:0]  op;
        logic        denied;
        logic        corrupt;
        logic [63:0] data;
        logic [2:0]  size;
        logic        source;
    } exp_t;

    exp_t exp_q[$];
    logic [63:0] mem [0:1023];

`ifdef TL_BRAM_DEVICE_HINT_EN
    localparam logic ExpHintDenied = 1'b0;
`else
    localparam logic ExpHintDenied = 1'b1;
`endif

    tl_channel #(.SourceWidth(1), .SinkWidth(1), .AddrWidth(56), .DataWidth(64), .SizeWidth(3)) bus ();

    tl_bram_device dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .host         (bus),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wmask_o (sram_wmask),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural SRAM: byte-masked writes, registered reads.
    always @(posedge clk_i) begin
        if (sram_req && sram_we) begin
            for (int b = 0; b < 8; b++) begin
                if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
            write_count <= write_count + 1;
        end else if (sram_req) begin
            sram_rdata <= mem[sram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] op, input logic denied, input logic corrupt,
                            input logic [63:0] data, input logic [2:0] size, input logic src);
        exp_t e;
        e.op = op; e.denied = denied; e.corrupt = corrupt;
        e.data = data; e.size = size; e.source = src;
        exp_q.push_back(e);
    endtask

    task automatic send_a(input tl_a_op_e op, input logic [2:0] size, input logic [55:0] addr,
                          input logic [7:0] mask, input logic [63:0] data, input logic src);
        bit got;
        got = 1'b0;
        bus.a_valid = 1'b1; bus.a_opcode = op; bus.a_size = size; bus.a_address = addr;
        bus.a_mask = mask; bus.a_data = data; bus.a_source = src;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk_i);
            got = bus.a_ready;
        end
        if (!got) check_eq("a_ready_timeout", {63'd0, bus.a_ready}, 64'd1);
        @(posedge clk_i); #1;
        bus.a_valid = 1'b0;
        $display("A %s size=%0d addr=0x%0h mask=0x%0h data=0x%0h", op.name(), size, addr, mask, data);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        #1;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk_i); #1;
            n++;
        end
        if (exp_q.size() != 0) check_eq("d_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk_i); #1;
    endtask

    // d_ready: 0 = always ready, 1 = pattern 1,0,0,1, 2 = held low
    initial begin
        int ph;
        ph = 0;
        bus.d_ready = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            ph++;
            case (ready_mode)
                0:       bus.d_ready = 1'b1;
                1:       bus.d_ready = (ph % 4 == 0) || (ph % 4 == 3);
                default: bus.d_ready = 1'b0;
            endcase
        end
    end

    // D monitor
    initial begin
        exp_t e;
        logic [63:0] held_data;
        logic [2:0]  held_op;
        logic        held_denied;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (stall_pending) begin
                    check_eq("stall_valid", {63'd0, bus.d_valid}, 64'd1);
                    check_eq("stall_data", bus.d_data, held_data);
                    check_eq("stall_op", {61'd0, bus.d_opcode}, {61'd0, held_op});
                    check_eq("stall_denied", {63'd0, bus.d_denied}, {63'd0, held_denied});
                end
                stall_pending = 1'b0;
                if (bus.d_valid) begin
                    if (bus.d_ready) begin
                        if (exp_q.size() == 0) begin
                            check_eq("d_unexpected", {63'd0, bus.d_valid}, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            $display("D op=%0d denied=%0d corrupt=%0d data=0x%0h src=%0d size=%0d",
                                     bus.d_opcode, bus.d_denied, bus.d_corrupt, bus.d_data,
                                     bus.d_source, bus.d_size);
                            check_eq("d_opcode", {61'd0, bus.d_opcode}, {61'd0, e.op});
                            check_eq("d_denied", {63'd0, bus.d_denied}, {63'd0, e.denied});
                            check_eq("d_corrupt", {63'd0, bus.d_corrupt}, {63'd0, e.corrupt});
                            check_eq("d_data", bus.d_data, e.data);
                            check_eq("d_size", {61'd0, bus.d_size}, {61'd0, e.size});
                            check_eq("d_source", {63'd0, bus.d_source}, {63'd0, e.source});
                            check_eq("d_sink", {63'd0, bus.d_sink}, 64'd0);
                            check_eq("d_param", {62'd0, bus.d_param}, 64'd0);
                        end
                    end else begin
                        held_data = bus.d_data;
                        held_op = bus.d_opcode;
                        held_denied = bus.d_denied;
                        stall_pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wc_before;
        bus.a_valid = 1'b0; bus.a_opcode = TL_A_GET; bus.a_param = 3'd0; bus.a_size = 3'd0;
        bus.a_source = 1'b0; bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0;
        bus.a_corrupt = 1'b0; bus.b_ready = 1'b1; bus.c_valid = 1'b0; bus.e_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_a_ready", {63'd0, bus.a_ready}, 64'd0);
        check_eq("rst_d_valid", {63'd0, bus.d_valid}, 64'd0);
        check_eq("rst_sram_req", {63'd0, sram_req}, 64'd0);
        check_eq("rst_d_data", bus.d_data, 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("idle_a_ready", {63'd0, bus.a_ready}, 64'd1);
        @(posedge clk_i); #1;

        // Preload word 3, then single-beat Get with latency check
        push_exp(3'd0, 1'b0, 1'b0, 64'd0, 3'd3, 1'b0);
        send_a(TL_A_PUT_FULL, 3'd3, 56'h18, 8'hFF, 64'hDEAD, 1'b0);
        wait_done();
        check_eq("mem3", mem[3], 64'hDEAD);
        push_exp(3'd1, 1'b0, 1'b0, 64'hDEAD, 3'd3, 1'b1);
        send_a(TL_A_GET, 3'd3, 56'h18, 8'hFF, 64'd0, 1'b1);
        @(negedge clk_i);
        check_eq("get_lat_c1", {63'd0, bus.d_valid}, 64'd0);
        @(negedge clk_i);
        check_eq("get_lat_c2", {63'd0, bus.d_valid}, 64'd1);
        wait_done();

        // 4-beat PutFull then 4-beat Get
        push_exp(3'd0, 1'b0, 1'b0, 64'd0, 3'd5, 1'b0);
        for (int i = 1; i <= 4; i++) send_a(TL_A_PUT_FULL, 3'd5, 56'h40, 8'hFF, 64'(i), 1'b0);
        @(negedge clk_i);
        check_eq("put_ack_lat", {63'd0, bus.d_valid}, 64'd1);
        wait_done();
        for (int i = 0; i < 4; i++) check_eq("burst_mem", mem[8 + i], 64'(i + 1));
        for (int i = 1; i <= 4; i++) push_exp(3'd1, 1'b0, 1'b0, 64'(i), 3'd5, 1'b1);
        send_a(TL_A_GET, 3'd5, 56'h40, 8'hFF, 64'd0, 1'b1);
        wait_done();

        // PutPartial low half over a zeroed word
        push_exp(3'd0, 1'b0, 1'b0, 64'd0, 3'd3, 1'b0);
        send_a(TL_A_PUT_FULL, 3'd3, 56'h0, 8'hFF, 64'd0, 1'b0);
        wait_done();
        push_exp(3'd0, 1'b0, 1'b0, 64'd0, 3'd3, 1'b0);
        send_a(TL_A_PUT_PARTIAL, 3'd3, 56'h0, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        wait_done();
        push_exp(3'd1, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 3'd3, 1'b0);
        send_a(TL_A_GET, 3'd3, 56'h0, 8'hFF, 64'd0, 1'b0);
        wait_done();

        // Get burst under d_ready backpressure
        ready_mode = 1;
        for (int i = 1; i <= 4; i++) push_exp(3'd1, 1'b0, 1'b0, 64'(i), 3'd5, 1'b0);
        send_a(TL_A_GET, 3'd5, 56'h40, 8'hFF, 64'd0, 1'b0);
        wait_done();
        ready_mode = 0;
        @(posedge clk_i); #1;

        // LogicalData 2 beats: drained and denied, SRAM untouched
        push_exp(3'd0, 1'b0, 1'b0, 64'd0, 3'd3, 1'b0);
        send_a(TL_A_PUT_FULL, 3'd3, 56'h80, 8'hFF, 64'h55, 1'b0);
        wait_done();
        wc_before = write_count;
        push_exp(3'd1, 1'b1, 1'b1, 64'd0, 3'd4, 1'b1);
        push_exp(3'd1, 1'b1, 1'b1, 64'd0, 3'd4, 1'b1);
        send_a(TL_A_LOGICAL, 3'd4, 56'h80, 8'hFF, 64'h1111, 1'b1);
        send_a(TL_A_LOGICAL, 3'd4, 56'h80, 8'hFF, 64'h2222, 1'b1);
        wait_done();
        check_eq("drain_no_write", 64'(write_count), 64'(wc_before));
        check_eq("drain_mem16", mem[16], 64'h55);

        // Intent hint
        push_exp(3'd2, ExpHintDenied, 1'b0, 64'd0, 3'd3, 1'b0);
        send_a(TL_A_INTENT, 3'd3, 56'h0, 8'hFF, 64'd0, 1'b0);
        wait_done();

        // Reset in the middle of a stalled read burst
        ready_mode = 2;
        for (int i = 1; i <= 4; i++) push_exp(3'd1, 1'b0, 1'b0, 64'(i), 3'd5, 1'b0);
        send_a(TL_A_GET, 3'd5, 56'h40, 8'hFF, 64'd0, 1'b0);
        repeat (4) @(posedge clk_i);
        #2;
        check_eq("pre_rst_d_valid", {63'd0, bus.d_valid}, 64'd1);
        rst_i = 1'b1;
        #1;
        check_eq("async_rst_d_valid", {63'd0, bus.d_valid}, 64'd0);
        check_eq("async_rst_a_ready", {63'd0, bus.a_ready}, 64'd0);
        exp_q.delete();
        stall_pending = 1'b0;
        ready_mode = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("post_rst_a_ready", {63'd0, bus.a_ready}, 64'd1);
        check_eq("post_rst_d_valid", {63'd0, bus.d_valid}, 64'd0);
        @(posedge clk_i); #1;

        // Device still works after the abort
        push_exp(3'd1, 1'b0, 1'b0, 64'd2, 3'd3, 1'b1);
        send_a(TL_A_GET, 3'd3, 56'h48, 8'hFF, 64'd0, 1'b1);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
